// File: rtl/gray_evt_capture_if.sv
// Bus bundle for gray_evt_capture: encoder sample inputs, FIFO head
// handshake, occupancy and overflow status.
interface gray_evt_capture_if;
  logic       act;
  logic [2:0] y;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic [2:0] count;
  logic       ovf;
  logic       clr_ovf;

  // Producer/consumer side (drives encoder samples, ready and clear)
  modport master (
    output act, y, out_ready, clr_ovf,
    input  out_valid, out_code, count, ovf
  );

  // Capture block side
  modport slave (
    input  act, y, out_ready, clr_ovf,
    output out_valid, out_code, count, ovf
  );
endinterface

// File: rtl/gray_evt_capture.sv
// gray_evt_capture: debounces the Gray-coded index of an upstream 8:3
// priority encoder and logs each stable activation, as a binary code, into
// a 4-entry FIFO with a sticky overflow flag.
module gray_evt_capture #(
  parameter int unsigned STABLE = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  gray_evt_capture_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] STABLE_C = 4'(STABLE);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [2:0] code_q;

  logic [2:0] mem_q [DEPTH];
  logic [1:0] rd_ptr_q;
  logic [1:0] wr_ptr_q;
  logic [2:0] count_q;
  logic [2:0] count_d;
  logic       ovf_q;
  logic       ovf_d;

  logic [2:0] bin_s;
  logic       same_s;
  logic [3:0] cnt_inc_s;
  logic       push_s;
  logic       empty_s;
  logic       full_s;
  logic       pop_s;
  logic       wr_s;
  logic       drop_s;

  // Gray-to-binary conversion of the live encoder sample
  assign bin_s     = {bus.y[2], bus.y[2] ^ bus.y[1], bus.y[2] ^ bus.y[1] ^ bus.y[0]};
  assign same_s    = (bin_s == code_q);
  assign cnt_inc_s = cnt_q + 4'd1;

  // Event push decision for this edge, taken from the current FSM state
  always_comb begin
    push_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.act && (STABLE_C == 4'd1)) begin
          push_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      SETTLE: begin
        if (bus.act && same_s && (cnt_inc_s == STABLE_C)) begin
          push_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      HOLD: begin
        if (bus.act && !same_s && (STABLE_C == 4'd1)) begin
          push_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      default: push_s = 1'b0;
    endcase
  end

  // Debounce FSM: track the captured code and how long it has been stable
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      code_q  <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.act) begin
            code_q  <= bin_s;
            cnt_q   <= 4'd1;
            state_q <= (STABLE_C == 4'd1) ? HOLD : SETTLE;
          end
        end
        SETTLE: begin
          if (!bus.act) begin
            state_q <= IDLE;
          end else if (!same_s) begin
            code_q <= bin_s;
            cnt_q  <= 4'd1;
          end else begin
            cnt_q <= cnt_inc_s;
            if (cnt_inc_s == STABLE_C) begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!bus.act) begin
            state_q <= IDLE;
          end else if (!same_s) begin
            // A new code re-arms the debounce; with STABLE=1 it is logged at once
            code_q  <= bin_s;
            cnt_q   <= 4'd1;
            state_q <= (STABLE_C == 4'd1) ? HOLD : SETTLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  assign empty_s = (count_q == 3'd0);
  assign full_s  = (count_q == 3'd4);
  assign pop_s   = bus.out_ready && !empty_s;
  // A full FIFO still accepts a push when the head leaves on the same edge
  assign wr_s    = push_s && (!full_s || pop_s);
  assign drop_s  = push_s && full_s && !pop_s;

  // Next occupancy: +1 on write only, -1 on pop only
  always_comb begin
    count_d = count_q;
    case ({wr_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Sticky overflow: a drop on the same edge beats a clear
  always_comb begin
    ovf_d = ovf_q;
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Event FIFO storage, pointers, occupancy and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 3'd0;
      end
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_s) begin
        mem_q[wr_ptr_q] <= bin_s;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.out_valid = !empty_s;
  assign bus.out_code  = empty_s ? 3'd0 : mem_q[rd_ptr_q];
  assign bus.count     = count_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_gray_evt_capture.sv
// Self-checking bench for gray_evt_capture: directed vector table, a few
// hand-written multi-cycle sequences, and randomized stimulus against a
// run-length/queue reference model, for STABLE=2 and STABLE=1 instances.
module tb_gray_evt_capture;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  gray_evt_capture_if if2 ();
  gray_evt_capture_if if1 ();

  gray_evt_capture #(.STABLE(2)) u2 (.clk(clk), .rst(rst), .bus(if2));
  gray_evt_capture #(.STABLE(1)) u1 (.clk(clk), .rst(rst), .bus(if1));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       r;
    logic       a;
    logic [2:0] c;   // binary code; driven as its Gray equivalent
    logic       rd;
    logic       cl;
    logic       v;
    logic [2:0] ec;
    logic [2:0] en;
    logic       o;
  } vec_t;

  vec_t tbl[$];

  // reference model state
  int         m_stable;
  int         m_run;
  logic [2:0] m_last;
  logic       m_ovf;
  logic [2:0] m_q[$];

  function automatic logic [2:0] gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic [2:0] c,
                       input logic rd, input logic cl);
    rst         = r;
    if2.act     = a;  if1.act     = a;
    if2.y       = gray(c); if1.y  = gray(c);
    if2.out_ready = rd; if1.out_ready = rd;
    if2.clr_ovf = cl; if1.clr_ovf = cl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input int sel, input string tag, input logic v,
                         input logic [2:0] c, input logic [2:0] n, input logic o);
    logic       gv;
    logic [2:0] gc;
    logic [2:0] gn;
    logic       go;
    if (sel == 1) begin
      gv = if1.out_valid; gc = if1.out_code; gn = if1.count; go = if1.ovf;
    end else begin
      gv = if2.out_valid; gc = if2.out_code; gn = if2.count; go = if2.ovf;
    end
    chk({tag, ".valid"}, {3'd0, gv}, {3'd0, v});
    chk({tag, ".code"},  {1'b0, gc}, {1'b0, c});
    chk({tag, ".count"}, {1'b0, gn}, {1'b0, n});
    chk({tag, ".ovf"},   {3'd0, go}, {3'd0, o});
  endtask

  task automatic add(input int r, input int a, input int c, input int rd, input int cl,
                     input int v, input int ec, input int en, input int o);
    vec_t e;
    e.r = r[0]; e.a = a[0]; e.c = c[2:0]; e.rd = rd[0]; e.cl = cl[0];
    e.v = v[0]; e.ec = ec[2:0]; e.en = en[2:0]; e.o = o[0];
    tbl.push_back(e);
  endtask

  // Reference: an event is logged when the run of consecutive act=1 samples
  // carrying the same code reaches exactly STABLE; FIFO is a plain queue.
  task automatic model_step(input logic r, input logic a, input logic [2:0] b,
                            input logic rd, input logic cl);
    bit pop;
    bit push;
    bit drop;
    if (r) begin
      m_run = 0;
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      pop  = rd && (m_q.size() > 0);
      push = 1'b0;
      drop = 1'b0;
      if (a) begin
        m_run  = (m_run > 0 && b == m_last) ? m_run + 1 : 1;
        m_last = b;
        push   = (m_run == m_stable);
      end else begin
        m_run = 0;
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < 4) m_q.push_back(b);
        else drop = 1'b1;
      end
      m_ovf = drop ? 1'b1 : (cl ? 1'b0 : m_ovf);
    end
  endtask

  initial begin
    int         n0;
    int         n1;
    logic       ra;
    logic       rr;
    logic       rd;
    logic       cl;
    logic [2:0] yc;
    int         pct;

    drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    // ---------------- directed vector table (STABLE=2 instance) -----------
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);                 // reset state
    // basic: code 4 held three cycles
    add(0, 1, 4, 0, 0, 0, 0, 0, 0);
    add(0, 1, 4, 0, 0, 1, 4, 1, 0);
    add(0, 1, 4, 0, 0, 1, 4, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // glitch: 1 for one cycle, then 2 for two cycles
    add(0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 2, 0, 0, 0, 0, 0, 0);
    add(0, 1, 2, 0, 0, 1, 2, 1, 0);
    add(0, 0, 0, 0, 0, 1, 2, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // overflow: log 0..4 with out_ready low
    for (int c = 0; c < 5; c++) begin
      n0 = (c < 4) ? c : 4;
      n1 = (c + 1 <= 4) ? c + 1 : 4;
      add(0, 1, c, 0, 0, (n0 != 0) ? 1 : 0, 0, n0, 0);
      add(0, 1, c, 0, 0, 1, 0, n1, (c == 4) ? 1 : 0);
      add(0, 0, 0, 0, 0, 1, 0, n1, (c == 4) ? 1 : 0);
    end
    for (int k = 1; k <= 4; k++) begin
      add(0, 0, 0, 1, 0, (k < 4) ? 1 : 0, (k < 4) ? k : 0, 4 - k, 1);
    end
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);                 // clr_ovf
    // full with simultaneous pop: fill 3..6, then push 7 while popping
    for (int c = 3; c < 7; c++) begin
      add(0, 1, c, 0, 0, (c != 3) ? 1 : 0, (c != 3) ? 3 : 0, c - 3, 0);
      add(0, 1, c, 0, 0, 1, 3, c - 2, 0);
      add(0, 0, 0, 0, 0, 1, 3, c - 2, 0);
    end
    add(0, 1, 7, 0, 0, 1, 3, 4, 0);
    add(0, 1, 7, 1, 0, 1, 4, 4, 0);
    for (int k = 1; k <= 4; k++) begin
      add(0, 0, 0, 1, 0, (k < 4) ? 1 : 0, (k < 4) ? 4 + k : 0, 4 - k, 0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].a, tbl[i].c, tbl[i].rd, tbl[i].cl);
      tick();
      chk_out(2, $sformatf("vec%0d", i), tbl[i].v, tbl[i].ec, tbl[i].en, tbl[i].o);
    end

    // ---------------- reset mid-operation (STABLE=2) ----------------------
    for (int c = 1; c <= 3; c++) begin
      drive(1'b0, 1'b1, 3'(c), 1'b0, 1'b0); tick(); tick();
      drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0); tick();
    end
    drive(1'b0, 1'b1, 3'd5, 1'b0, 1'b0); tick();
    chk_out(2, "rstmid.pre", 1'b1, 3'd1, 3'd3, 1'b0);
    drive(1'b1, 1'b1, 3'd5, 1'b1, 1'b1); tick();
    chk_out(2, "rstmid.rst", 1'b0, 3'd0, 3'd0, 1'b0);
    drive(1'b0, 1'b1, 3'd5, 1'b0, 1'b0); tick();
    chk_out(2, "rstmid.e1", 1'b0, 3'd0, 3'd0, 1'b0);
    tick();
    chk_out(2, "rstmid.e2", 1'b1, 3'd5, 3'd1, 1'b0);

    // ---------------- STABLE=1: one entry per changing cycle --------------
    drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0); tick();
    chk_out(1, "s1.rst", 1'b0, 3'd0, 3'd0, 1'b0);
    drive(1'b0, 1'b1, 3'd0, 1'b0, 1'b0); tick();
    chk_out(1, "s1.e0", 1'b1, 3'd0, 3'd1, 1'b0);
    drive(1'b0, 1'b1, 3'd1, 1'b0, 1'b0); tick();
    chk_out(1, "s1.e1", 1'b1, 3'd0, 3'd2, 1'b0);
    drive(1'b0, 1'b1, 3'd2, 1'b0, 1'b0); tick();
    chk_out(1, "s1.e2", 1'b1, 3'd0, 3'd3, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b0); tick();
    chk_out(1, "s1.p1", 1'b1, 3'd1, 3'd2, 1'b0);
    tick();
    chk_out(1, "s1.p2", 1'b1, 3'd2, 3'd1, 1'b0);
    tick();
    chk_out(1, "s1.p3", 1'b0, 3'd0, 3'd0, 1'b0);

    // ---------------- randomized vs reference model -----------------------
    for (int sel = 2; sel >= 1; sel--) begin
      m_stable = sel;
      drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0); tick();
      model_step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      chk_out(sel, $sformatf("rnd%0d.rst", sel), 1'b0, 3'd0, 3'd0, 1'b0);
      yc = 3'd0;
      for (int i = 0; i < 1500; i++) begin
        case ((i / 200) % 3)
          0:       pct = 10;
          1:       pct = 50;
          default: pct = 90;
        endcase
        if ($urandom_range(0, 3) == 0) yc = 3'($urandom_range(0, 7));
        ra = ($urandom_range(0, 7) != 0);
        rr = ($urandom_range(0, 299) == 0);
        rd = ($urandom_range(0, 99) < pct);
        cl = ($urandom_range(0, 15) == 0);
        drive(rr, ra, yc, rd, cl);
        tick();
        model_step(rr, ra, yc, rd, cl);
        chk_out(sel, $sformatf("rnd%0d.c%0d", sel, i), (m_q.size() != 0),
                (m_q.size() != 0) ? m_q[0] : 3'd0, 3'(m_q.size()), m_ovf);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_evt_capture.md
GRAY_EVT_CAPTURE -- requirements
Module: gray_evt_capture

Interface
REQ-001 Parameter STABLE, default 2, meaning consecutive identical samples (act=1, same code) required before an event is logged; legal range 1..15.
REQ-002 Parameter DEPTH, fixed 4, meaning event FIFO depth in entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 act  input  1  active flag from the upstream Gray-coded 8:3 priority encoder.
REQ-006 y  input  3  Gray-coded priority index from the upstream encoder.
REQ-007 out_valid  output  1  FIFO head entry valid.
REQ-008 out_ready  input  1  consumer accepts head entry when out_valid=1.
REQ-009 out_code  output  3  binary index of FIFO head entry.
REQ-010 count  output  3  current FIFO occupancy, 0..4.
REQ-011 ovf  output  1  sticky overflow flag.
REQ-012 clr_ovf  input  1  clears ovf.

Function
REQ-013 The block SHALL sample act and y on every rising edge, with no input registering, and SHALL convert Gray to binary as b2=y2, b1=y2^y1, b0=b1^y0.
REQ-014 The FSM SHALL have states IDLE, SETTLE and HOLD, plus a 4-bit stability counter cnt.
REQ-015 IDLE: act=0 -> stay; act=1 -> capture y, set cnt=1; if STABLE=1 push the event and go HOLD, else go SETTLE.
REQ-016 SETTLE: act=0 -> IDLE, no push; y differs from the captured code -> recapture y, set cnt=1, stay; y equal -> increment cnt; when the incremented cnt equals STABLE, push the event and go HOLD.
REQ-017 HOLD: act=0 -> IDLE; y equal -> stay, no further push; y differs -> recapture y, set cnt=1, go SETTLE (push immediately and stay HOLD if STABLE=1).
REQ-018 Latency: with STABLE=2, an empty FIFO, and act=1 with constant y sampled at edges k and k+1, out_valid SHALL be 1 after edge k+1, with out_code equal to the binary value.
REQ-019 Pop SHALL occur at an edge where out_valid=1 and out_ready=1.
REQ-020 out_valid SHALL equal (count!=0), and out_code SHALL show the head entry, or 0 when empty.
REQ-021 Push when not full SHALL write the entry.
REQ-022 Push when full with a simultaneous pop SHALL be accepted, leaving count at 4.
REQ-023 Push when full without a pop SHALL be dropped, with ovf set to 1 after that edge; FIFO contents SHALL be unchanged.
REQ-024 Simultaneous push and pop when the FIFO is empty: the pop SHALL be ignored (out_valid=0) and the push SHALL be written.
REQ-025 Simultaneous push and pop otherwise SHALL leave count unchanged.
REQ-026 FIFO order SHALL be strict first-in first-out; read and write pointers SHALL be 2-bit and wrap 3->0.
REQ-027 count SHALL be 3-bit saturating-free arithmetic: +1 on push-only, -1 on pop-only, unchanged otherwise.
REQ-028 clr_ovf=1 SHALL clear ovf at the edge; if an overflow drop occurs at the same edge, ovf SHALL read 1 (set wins).
REQ-029 out_ready SHALL have no effect when out_valid=0, and out_valid SHALL not drop without a pop or reset.

Reset
REQ-030 rst=1 at an edge SHALL force state IDLE, cnt=0, captured code 0, pointers 0, count=0, out_valid=0, out_code=0 and ovf=0, overriding all other inputs including clr_ovf and a pending push or pop.
REQ-031 Reset mid-SETTLE or with a non-empty FIFO SHALL discard the pending event and all stored entries; after rst deasserts, a held act=1 SHALL be treated as a new activation from IDLE.

Verification
REQ-032 Basic: STABLE=2, out_ready=0, act=1 and y=3'b110 for 3 cycles -> exactly one entry; out_valid=1 after the 2nd edge, out_code=3'b100, count=1.
REQ-033 Glitch: y=3'b001 for 1 cycle, then y=3'b011 for 2 cycles, act=1 throughout -> single entry with out_code=3'b010; code 1 is never logged.
REQ-034 Overflow: out_ready=0, log codes 0,1,2,3,4 by alternating act low and high -> count=4, ovf=1, and pops return 0,1,2,3 in order; clr_ovf then gives ovf=0.
REQ-035 Full with pop: FIFO full, out_ready=1 on the same edge as a push of code 7 -> no ovf, count stays 4, and code 7 is the last entry popped.
REQ-036 Reset mid-op: 3 entries stored, FSM in SETTLE, rst pulsed 1 cycle -> count=0, out_valid=0, ovf=0; with act still 1 and y constant, a new entry appears 2 edges after rst deasserts.
REQ-037 STABLE=1: y steps 3'b000 -> 3'b001 -> 3'b011 on consecutive cycles with act=1 -> entries 0, 1, 2, one per cycle.
